// File: rtl/nrisc_pkg.sv
// ---------------------------------------------------------------------------
// nrisc_pkg
//   Definitions shared by the register-bank write side and its decoder:
//     - NREG         : number of registers in the bank.
//     - DEFAULT_TAM  : default register data width in bits.
//     - wr_op_e      : write operation encodings (load / inc / dec / clear).
// ---------------------------------------------------------------------------
package nrisc_pkg;

  localparam int unsigned NREG        = 16;
  localparam int unsigned DEFAULT_TAM = 16;

  typedef enum logic [1:0] {
    WR_OP_LOAD = 2'b00,
    WR_OP_INC  = 2'b01,
    WR_OP_DEC  = 2'b10,
    WR_OP_CLR  = 2'b11
  } wr_op_e;

endpackage : nrisc_pkg

// File: rtl/dec4x16.sv
// ---------------------------------------------------------------------------
// dec4x16
//   Combinational 4-to-16 one-hot decoder with enable. This is the write-side
//   counterpart of the mux16x1 read path.
//   Ports:
//     en     : when 0 the output is all zero.
//     addr   : index of the bit to set.
//     onehot : 1 << addr when en, otherwise 0.
// ---------------------------------------------------------------------------
module dec4x16 (
  input  logic        en,
  input  logic [3:0]  addr,
  output logic [15:0] onehot
);

  always_comb begin
    // NOTE: assign a default before any conditional write so every path
    // drives the output and no latch is inferred.
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule : dec4x16

// File: rtl/regbank_wr_demux.sv
// ---------------------------------------------------------------------------
// regbank_wr_demux
//   Write side of the 16-entry register bank. A request is captured into a
//   one-entry pending stage (valid/ready handshake) and committed on the next
//   edge where WR_stall is low, applying load / inc / dec / clear to the
//   addressed register. All registers are exposed flattened for the read muxes.
//   Ports:
//     clk, rst   : rising-edge clock, synchronous active-high reset.
//     WR_valid   : request present.
//     WR_ready   : pending stage can accept this cycle (combinational).
//     WR_addr    : destination register index.
//     WR_op      : 00 load, 01 inc, 10 dec, 11 clear.
//     WR_data    : load data (ignored for other ops).
//     WR_stall   : holds the pending entry uncommitted.
//     REG_flat   : register k at bits [k*TAM +: TAM].
//     WR_onehot  : one-hot of the write committed at the previous edge, else 0.
//     WR_busy    : pending entry valid.
// ---------------------------------------------------------------------------
module regbank_wr_demux
  import nrisc_pkg::*;
#(
  parameter int unsigned TAM     = DEFAULT_TAM,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                WR_valid,
  output logic                WR_ready,
  input  logic [3:0]          WR_addr,
  input  logic [1:0]          WR_op,
  input  logic [TAM-1:0]      WR_data,
  input  logic                WR_stall,
  output logic [NREG*TAM-1:0] REG_flat,
  output logic [NREG-1:0]     WR_onehot,
  output logic                WR_busy
);

  // Pending stage
  logic           pend_valid_q, pend_valid_d;
  logic [3:0]     pend_addr_q,  pend_addr_d;
  wr_op_e         pend_op_q,    pend_op_d;
  logic [TAM-1:0] pend_data_q,  pend_data_d;

  // Register bank and commit indicator
  logic [TAM-1:0]  regs_q [NREG];
  logic [TAM-1:0]  regs_d [NREG];
  logic [NREG-1:0] onehot_q, onehot_d;

  logic            accept;
  logic            commit;
  logic [NREG-1:0] wr_en;

  // Ready depends only on whether the entry can leave this cycle, so the stage
  // drains and refills at the same edge for full throughput.
  assign WR_ready = ~pend_valid_q | ~WR_stall;
  assign accept   = WR_valid & WR_ready;
  assign commit   = pend_valid_q & ~WR_stall;

  dec4x16 u_dec (
    .en     (commit),
    .addr   (pend_addr_q),
    .onehot (wr_en)
  );

  // Pending-stage next state
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_op_d    = pend_op_q;
    pend_data_d  = pend_data_q;
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = WR_addr;
      pend_op_d    = wr_op_e'(WR_op);
      pend_data_d  = WR_data;
    end else if (commit) begin
      pend_valid_d = 1'b0;
    end
  end

  // Register update. Inc/dec use the value held at the commit edge, so
  // consecutive commits to one register accumulate.
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NREG; k++) begin
      if (wr_en[k]) begin
        unique case (pend_op_q)
          WR_OP_LOAD: regs_d[k] = pend_data_q;
          WR_OP_INC:  regs_d[k] = regs_q[k] + TAM'(1);
          WR_OP_DEC:  regs_d[k] = regs_q[k] - TAM'(1);
          WR_OP_CLR:  regs_d[k] = '0;
          default:    regs_d[k] = regs_q[k];
        endcase
      end
    end
    // Register 0 discards writes; the decoder still reports the commit.
    if (R0_ZERO) begin
      regs_d[0] = '0;
    end
  end

  assign onehot_d = wr_en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_op_q    <= WR_OP_LOAD;
      pend_data_q  <= '0;
      onehot_q     <= '0;
      // NOTE: the bank is architectural state with a defined reset value, so
      // it is built from flops and every entry is cleared, not left as RAM.
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_op_q    <= pend_op_d;
      pend_data_q  <= pend_data_d;
      onehot_q     <= onehot_d;
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign REG_flat[g*TAM +: TAM] = regs_q[g];
  end

  assign WR_onehot = onehot_q;
  assign WR_busy   = pend_valid_q;

endmodule : regbank_wr_demux

// File: tb/tb_regbank_wr_demux.sv
module tb_regbank_wr_demux;
  import nrisc_pkg::*;

  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [3:0]    wr_addr;
  logic [1:0]    wr_op;
  logic [TW-1:0] wr_data;
  logic          wr_stall;

  logic          ready_z, busy_z, ready_n, busy_n;
  logic [255:0]  flat_z, flat_n;
  logic [15:0]   oh_z, oh_n;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // R0_ZERO = 1 instance
  regbank_wr_demux #(.TAM(TW), .R0_ZERO(1'b1)) u_r0z (
    .clk(clk), .rst(rst), .WR_valid(wr_valid), .WR_ready(ready_z),
    .WR_addr(wr_addr), .WR_op(wr_op), .WR_data(wr_data), .WR_stall(wr_stall),
    .REG_flat(flat_z), .WR_onehot(oh_z), .WR_busy(busy_z)
  );

  // R0_ZERO = 0 instance, same stimulus
  regbank_wr_demux #(.TAM(TW), .R0_ZERO(1'b0)) u_r0n (
    .clk(clk), .rst(rst), .WR_valid(wr_valid), .WR_ready(ready_n),
    .WR_addr(wr_addr), .WR_op(wr_op), .WR_data(wr_data), .WR_stall(wr_stall),
    .REG_flat(flat_n), .WR_onehot(oh_n), .WR_busy(busy_n)
  );

  function automatic logic [15:0] rg(input logic [255:0] f, input int k);
    return f[k*16 +: 16];
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one edge.
  task automatic send(input logic [3:0] a, input logic [1:0] op, input logic [15:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_op    = op;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  logic [255:0] exp_flat;
  logic [15:0]  exp_oh;

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_op = '0; wr_data = '0; wr_stall = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_flat", flat_z, '0);
    check("rst_onehot", {240'd0, oh_z}, '0);
    check("rst_busy", {255'd0, busy_z}, '0);
    check("rst_ready", {255'd0, ready_z}, 256'd1);

    // Load r5 = 0x1234
    send(4'd5, WR_OP_LOAD, 16'h1234);
    check("load_busy", {255'd0, busy_z}, 256'd1);
    check("load_r5_before", {240'd0, rg(flat_z, 5)}, '0);
    step();
    check("load_flat", flat_z, 256'h1234 << 80);
    check("load_onehot", {240'd0, oh_z}, 256'h0020);
    check("load_idle_busy", {255'd0, busy_z}, '0);
    step();
    check("onehot_one_cycle", {240'd0, oh_z}, '0);

    // Wrap-around on r3
    send(4'd3, WR_OP_LOAD, 16'hFFFF); step();
    check("r3_load", {240'd0, rg(flat_z, 3)}, 256'hFFFF);
    send(4'd3, WR_OP_INC, 16'h0000); step();
    check("r3_inc_wrap", {240'd0, rg(flat_z, 3)}, 256'h0000);
    send(4'd3, WR_OP_DEC, 16'h5A5A); step();
    check("r3_dec_wrap", {240'd0, rg(flat_z, 3)}, 256'hFFFF);
    send(4'd3, WR_OP_CLR, 16'h5A5A); step();
    check("r3_clr", {240'd0, rg(flat_z, 3)}, 256'h0000);

    // Back-to-back incs of r7
    wr_valid = 1'b1; wr_addr = 4'd7; wr_op = WR_OP_INC; wr_data = 16'h0;
    step();
    check("b2b_ready", {255'd0, ready_z}, 256'd1);
    step();
    check("b2b_r7_1", {240'd0, rg(flat_z, 7)}, 256'd1);
    step();
    wr_valid = 1'b0;
    check("b2b_r7_2", {240'd0, rg(flat_z, 7)}, 256'd2);
    step();
    check("b2b_r7_3", {240'd0, rg(flat_z, 7)}, 256'd3);
    check("b2b_onehot", {240'd0, oh_z}, 256'h0080);

    // Stall with empty stage accepts, then holds
    wr_stall = 1'b1;
    #1;
    check("stall_empty_ready", {255'd0, ready_z}, 256'd1);
    send(4'd2, WR_OP_LOAD, 16'hBEEF);
    check("stall_busy", {255'd0, busy_z}, 256'd1);
    check("stall_ready", {255'd0, ready_z}, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_r2_held", {240'd0, rg(flat_z, 2)}, '0);
      check("stall_onehot", {240'd0, oh_z}, '0);
      check("stall_busy_held", {255'd0, busy_z}, 256'd1);
    end
    wr_stall = 1'b0;
    #1;
    check("unstall_ready", {255'd0, ready_z}, 256'd1);
    step();
    check("unstall_r2", {240'd0, rg(flat_z, 2)}, 256'hBEEF);
    check("unstall_onehot", {240'd0, oh_z}, 256'h0004);
    check("unstall_busy", {255'd0, busy_z}, '0);

    // Register 0 behaviour in both configurations
    send(4'd0, WR_OP_LOAD, 16'hAAAA); step();
    check("r0z_value", {240'd0, rg(flat_z, 0)}, '0);
    check("r0z_onehot", {240'd0, oh_z}, 256'h0001);
    check("r0n_value", {240'd0, rg(flat_n, 0)}, 256'hAAAA);
    check("r0n_onehot", {240'd0, oh_n}, 256'h0001);

    // Reset mid-operation: stalled pending r9, then reset with a same-edge request
    wr_stall = 1'b1;
    send(4'd9, WR_OP_LOAD, 16'h5555);
    check("mid_busy", {255'd0, busy_z}, 256'd1);
    rst = 1'b1; wr_stall = 1'b0;
    wr_valid = 1'b1; wr_addr = 4'd4; wr_op = WR_OP_LOAD; wr_data = 16'h7777;
    step();
    rst = 1'b0; wr_valid = 1'b0;
    check("mid_busy_cleared", {255'd0, busy_z}, '0);
    check("mid_flat_z", flat_z, '0);
    check("mid_flat_n", flat_n, '0);
    check("mid_onehot", {240'd0, oh_z}, '0);
    step();
    check("mid_r4_ignored", {240'd0, rg(flat_z, 4)}, '0);
    check("mid_r9_dropped", {240'd0, rg(flat_z, 9)}, '0);
    check("mid_onehot_after", {240'd0, oh_z}, '0);

    // Full throughput: rk = k for k = 0..15 with valid held high
    wr_valid = 1'b1; wr_op = WR_OP_LOAD;
    for (int k = 0; k < 16; k++) begin
      wr_addr = 4'(k);
      wr_data = 16'(k);
      #1;
      check("tput_ready", {255'd0, ready_z}, 256'd1);
      @(posedge clk); #1;
      exp_oh = (k == 0) ? 16'h0000 : (16'h0001 << (k - 1));
      check("tput_onehot", {240'd0, oh_z}, {240'd0, exp_oh});
    end
    wr_valid = 1'b0;
    step();
    check("tput_onehot_last", {240'd0, oh_z}, 256'h8000);
    exp_flat = '0;
    for (int k = 1; k < 16; k++) exp_flat[k*16 +: 16] = 16'(k);
    check("tput_flat_z", flat_z, exp_flat);
    check("tput_flat_n", flat_n, exp_flat);
    step();
    check("tput_idle_onehot", {240'd0, oh_z}, '0);
    check("tput_idle_busy", {255'd0, busy_z}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_regbank_wr_demux
